vote_session_controller: RTL and testbench

- Sequences voting sessions for a multi-candidate machine.
- Consumes per-candidate debounced/long-press outputs (one valid_vote pulse plus one pressed_level per candidate button) and accepts exactly one vote per session.
- Maintains saturating per-candidate and total tallies, and enforces a lockout plus button-release interlock between voters.
- Provides a results mode that reads tallies out by candidate index.

---
 rtl/vote_session_controller.sv | 147 ++++++++++++++
 tb/tb_vote_session_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_controller.sv
// vote_session_controller
// Accepts one vote per session from per-candidate vote pulses, keeps saturating
// per-candidate and total tallies, then enforces a fixed lockout and a
// button-release interlock before arming for the next voter. A results mode
// reads tallies out by candidate index.
module vote_session_controller #(
   parameter  int NUM_CANDIDATES = 4,
   parameter  int COUNT_WIDTH    = 8,
   parameter  int LOCKOUT_CYCLES = 100,
   localparam int IDXW           = $clog2(NUM_CANDIDATES)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CANDIDATES-1:0] vote_valid,
   input  logic [NUM_CANDIDATES-1:0] pressed_level,
   input  logic                      mode,
   input  logic [IDXW-1:0]           sel,
   output logic [COUNT_WIDTH-1:0]    tally_out,
   output logic [COUNT_WIDTH-1:0]    total_votes,
   output logic                      vote_ack,
   output logic [IDXW-1:0]           vote_cand,
   output logic                      reject,
   output logic                      overflow,
   output logic                      busy
);

   localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCKOUT_CYCLES - 1);

   localparam logic [2:0] S_ARMED   = 3'd0;
   localparam logic [2:0] S_RECORD  = 3'd1;
   localparam logic [2:0] S_REJECT  = 3'd2;
   localparam logic [2:0] S_LOCKOUT = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_RESULTS = 3'd5;

   logic [2:0]             state_q, state_d;
   logic [IDXW-1:0]        idx_q, idx_d;
   logic [LCW-1:0]         lock_q, lock_d;
   logic [COUNT_WIDTH-1:0] tally_q [NUM_CANDIDATES];
   logic [COUNT_WIDTH-1:0] tally_d [NUM_CANDIDATES];
   logic [COUNT_WIDTH-1:0] total_q, total_d;
   logic                   ovf_q, ovf_d;
   logic [COUNT_WIDTH-1:0] tally_out_q, rd_val;
   logic [1:0]             hit_cnt;
   logic [IDXW-1:0]        hit_idx;

   // Classify the vote request bits: none, exactly one (with its index), or several.
   always_comb begin
      hit_cnt = '0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
         if (vote_valid[i]) begin
            if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
            hit_idx = IDXW'(i);
         end
      end
   end

   // Session sequencing; results mode wins over a same-cycle vote in ARMED.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lock_d  = lock_q;
      case (state_q)
         S_ARMED: begin
            if (mode) begin
               state_d = S_RESULTS;
            end else if (hit_cnt == 2'd1) begin
               idx_d   = hit_idx;
               state_d = S_RECORD;
            end else if (hit_cnt == 2'd2) begin
               state_d = S_REJECT;
            end
         end
         S_RECORD: begin
            lock_d  = '0;
            state_d = S_LOCKOUT;
         end
         S_REJECT:  state_d = S_RELEASE;
         S_LOCKOUT: begin
            if (lock_q == LOCK_LAST) state_d = S_RELEASE;
            else                     lock_d  = lock_q + 1'b1;
         end
         S_RELEASE: if (pressed_level == '0) state_d = S_RELEASE == S_RELEASE ? S_ARMED : S_ARMED;
         S_RESULTS: if (!mode) state_d = S_RELEASE;
         default:   state_d = S_ARMED;
      endcase
   end

   // Saturating tally and total update, applied on the edge that leaves RECORD so
   // a reset during RECORD discards the vote in flight.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CANDIDATES; i++) tally_d[i] = tally_q[i];
      total_d = total_q;
      ovf_d   = ovf_q;
      if (state_q == S_RECORD) begin
         for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
            if (idx_q == IDXW'(i)) begin
               if (tally_q[i] == '1) ovf_d      = 1'b1;
               else                  tally_d[i] = tally_q[i] + 1'b1;
            end
         end
         if (total_q == '1) ovf_d   = 1'b1;
         else               total_d = total_q + 1'b1;
      end
   end

   // Readout mux; reads the next-state tallies so the cycle after RECORD already
   // shows the updated count. Out-of-range indices read as zero.
   always_comb begin
      rd_val = '0;
      for (int unsigned i = 0; i < NUM_CANDIDATES; i++) begin
         if (sel == IDXW'(i)) rd_val = tally_d[i];
      end
   end

   // State, counters and readout registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_ARMED;
         idx_q       <= '0;
         lock_q      <= '0;
         tally_q     <= '{default: '0};
         total_q     <= '0;
         ovf_q       <= 1'b0;
         tally_out_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lock_q      <= lock_d;
         tally_q     <= tally_d;
         total_q     <= total_d;
         ovf_q       <= ovf_d;
         tally_out_q <= rd_val;
      end
   end

   assign tally_out   = tally_out_q;
   assign total_votes = total_q;
   assign overflow    = ovf_q;
   assign vote_cand   = idx_q;
   assign vote_ack    = (state_q == S_RECORD);
   assign reject      = (state_q == S_REJECT);
   assign busy        = (state_q != S_ARMED);

endmodule

// File: tb/tb_vote_session_controller.sv
// Testbench for vote_session_controller: table-driven vote transactions, a
// scoreboard queue of expected ack/reject events, and hand-written sequences
// for ignored votes, results readout, reset aborts and saturation.
module tb_vote_session_controller;

   localparam int NC   = 5;
   localparam int CW   = 2;
   localparam int LC   = 4;
   localparam int IW   = $clog2(NC);
   localparam int MAXV = (1 << CW) - 1;

   logic           clock = 1'b0;
   logic           reset;
   logic [NC-1:0]  vote_valid;
   logic [NC-1:0]  pressed_level;
   logic           mode;
   logic [IW-1:0]  sel;
   logic [CW-1:0]  tally_out;
   logic [CW-1:0]  total_votes;
   logic           vote_ack;
   logic [IW-1:0]  vote_cand;
   logic           reject;
   logic           overflow;
   logic           busy;

   vote_session_controller #(
      .NUM_CANDIDATES(NC),
      .COUNT_WIDTH   (CW),
      .LOCKOUT_CYCLES(LC)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .vote_valid   (vote_valid),
      .pressed_level(pressed_level),
      .mode         (mode),
      .sel          (sel),
      .tally_out    (tally_out),
      .total_votes  (total_votes),
      .vote_ack     (vote_ack),
      .vote_cand    (vote_cand),
      .reject       (reject),
      .overflow     (overflow),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          ack;
      logic [IW-1:0] cand;
      logic          rej;
   } ev_t;

   typedef struct {
      logic [NC-1:0] vv;
      logic [NC-1:0] pl;
      int            hold;
      logic          ack;
      logic [IW-1:0] cand;
      logic          rej;
      int            busy;
   } vec_t;

   ev_t  evq[$];
   vec_t tbl[5];
   int   tests = 0;
   int   fails = 0;
   int   exp_tally[NC];
   int   exp_total;
   logic exp_ovf;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NC; i++) exp_tally[i] = 0;
      exp_total = 0;
      exp_ovf   = 1'b0;
   endtask

   task automatic model_vote(input int cand);
      if (exp_tally[cand] == MAXV) exp_ovf = 1'b1;
      else                         exp_tally[cand]++;
      if (exp_total == MAXV) exp_ovf = 1'b1;
      else                   exp_total++;
   endtask

   task automatic check_zero(input string name);
      check({name, "_tally_out"}, int'(tally_out), 0);
      check({name, "_total"},     int'(total_votes), 0);
      check({name, "_ack"},       int'(vote_ack), 0);
      check({name, "_cand"},      int'(vote_cand), 0);
      check({name, "_reject"},    int'(reject), 0);
      check({name, "_overflow"},  int'(overflow), 0);
      check({name, "_busy"},      int'(busy), 0);
   endtask

   // One vote transaction from ARMED; optionally injects extra pulses at cycles
   // inj_a/inj_b after the vote (mode only at inj_a). Counts busy cycles.
   task automatic vote_seq(input string name, input logic [NC-1:0] vv,
                           input logic [NC-1:0] pl, input int hold,
                           input logic e_ack, input logic [IW-1:0] e_cand,
                           input logic e_rej, input int e_busy,
                           input logic [NC-1:0] inj_vv, input logic inj_mode,
                           input int inj_a, input int inj_b);
      int   nb;
      logic b;
      evq.push_back('{ack: e_ack, cand: e_cand, rej: e_rej});
      @(negedge clock);
      vote_valid    = vv;
      pressed_level = (hold > 0) ? pl : '0;
      mode          = 1'b0;
      nb = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         b = busy;
         if (k == 1) begin
            check({name, "_ack_latency"}, int'(vote_ack), int'(e_ack));
            check({name, "_reject_latency"}, int'(reject), int'(e_rej));
            if (e_ack) check({name, "_cand"}, int'(vote_cand), int'(e_cand));
         end
         vote_valid = (k == inj_a || k == inj_b) ? inj_vv : '0;
         mode       = (k == inj_a) ? inj_mode : 1'b0;
         if (k == hold) pressed_level = '0;
         if (!b) break;
         nb++;
      end
      vote_valid    = '0;
      pressed_level = '0;
      mode          = 1'b0;
      check({name, "_busy_cycles"}, nb, e_busy);
      if (e_ack) model_vote(int'(e_cand));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int   nw;
      logic armed;

      tbl[0] = '{vv: 5'b00010, pl: 5'b00010, hold: 3, ack: 1'b1, cand: 3'd1, rej: 1'b0, busy: 6};
      tbl[1] = '{vv: 5'b00101, pl: 5'b00101, hold: 1, ack: 1'b0, cand: 3'd0, rej: 1'b1, busy: 2};
      tbl[2] = '{vv: 5'b10000, pl: 5'b10000, hold: 9, ack: 1'b1, cand: 3'd4, rej: 1'b0, busy: 9};
      tbl[3] = '{vv: 5'b11000, pl: 5'b00000, hold: 0, ack: 1'b0, cand: 3'd0, rej: 1'b1, busy: 2};
      tbl[4] = '{vv: 5'b11111, pl: 5'b11111, hold: 4, ack: 1'b0, cand: 3'd0, rej: 1'b1, busy: 4};

      reset = 1'b1; vote_valid = '0; pressed_level = '0; mode = 1'b0; sel = '0;
      model_clear();

      // Scoreboard monitor: every ack/reject pulse must match the next expected event.
      fork
         forever begin
            @(negedge clock);
            if (vote_ack || reject) begin
               check("ack_reject_exclusive", int'(vote_ack & reject), 0);
               if (evq.size() == 0) begin
                  check("unexpected_event", int'({vote_ack, reject}), 0);
               end else begin
                  ev_t e;
                  e = evq.pop_front();
                  check("sb_ack", int'(vote_ack), int'(e.ack));
                  check("sb_reject", int'(reject), int'(e.rej));
                  if (e.ack) check("sb_cand", int'(vote_cand), int'(e.cand));
               end
            end
         end
      join_none

      repeat (3) @(negedge clock);
      check_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         vote_seq($sformatf("vec%0d", i), tbl[i].vv, tbl[i].pl, tbl[i].hold,
                  tbl[i].ack, tbl[i].cand, tbl[i].rej, tbl[i].busy, '0, 1'b0, 0, 0);
         check($sformatf("vec%0d_total", i), int'(total_votes), exp_total);
         check($sformatf("vec%0d_overflow", i), int'(overflow), int'(exp_ovf));
      end

      // Vote on candidate 0 with its button held; candidate 2 pulses mid-lockout
      // (with mode) and again in release-wait must be ignored.
      vote_seq("ignored", 5'b00001, 5'b00001, 12, 1'b1, 3'd0, 1'b0, 12,
               5'b00100, 1'b1, 3, 8);
      check("ignored_total", int'(total_votes), exp_total);
      check("ignored_overflow", int'(overflow), int'(exp_ovf));

      // Results readout: mode beats a same-cycle vote; sweep all indices.
      @(negedge clock);
      mode = 1'b1; vote_valid = 5'b00100;
      @(negedge clock);
      vote_valid = '0;
      check("results_busy", int'(busy), 1);
      for (int s = 0; s < 8; s++) begin
         sel = IW'(s);
         if (s == 2) vote_valid = 5'b00010;
         @(negedge clock);
         vote_valid = '0;
         check($sformatf("readout_sel%0d", s), int'(tally_out), (s < NC) ? exp_tally[s] : 0);
      end
      pressed_level = 5'b00100; mode = 1'b0;
      @(negedge clock);
      vote_valid = 5'b00100;
      @(negedge clock);
      vote_valid = '0;
      check("results_release_busy", int'(busy), 1);
      pressed_level = '0;
      armed = 1'b0;
      for (nw = 0; nw < 10; nw++) begin
         @(negedge clock);
         if (!busy) begin armed = 1'b1; break; end
      end
      check("results_return_armed", int'(armed), 1);
      check("results_total", int'(total_votes), exp_total);
      sel = 3'd2;
      @(negedge clock);
      check("results_tally2", int'(tally_out), exp_tally[2]);

      // Reset during RECORD discards the vote in flight.
      sel = 3'd1;
      evq.push_back('{ack: 1'b1, cand: 3'd1, rej: 1'b0});
      @(negedge clock);
      vote_valid = 5'b00010; pressed_level = 5'b00010;
      @(negedge clock);
      vote_valid = '0;
      check("rst_record_ack", int'(vote_ack), 1);
      reset = 1'b1;
      @(negedge clock);
      check_zero("rst_record");
      reset = 1'b0; pressed_level = '0;
      model_clear();
      @(negedge clock);
      check("rst_record_tally1", int'(tally_out), 0);

      // Reset in the middle of LOCKOUT.
      evq.push_back('{ack: 1'b1, cand: 3'd2, rej: 1'b0});
      @(negedge clock);
      vote_valid = 5'b00100;
      @(negedge clock);
      vote_valid = '0;
      repeat (2) @(negedge clock);
      check("rst_lockout_busy_before", int'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      check_zero("rst_lockout");
      reset = 1'b0;

      // Saturation: four votes on candidate 3 with 2-bit counters.
      for (int v = 1; v <= 4; v++) begin
         vote_seq($sformatf("sat%0d", v), 5'b01000, '0, 0, 1'b1, 3'd3, 1'b0, LC + 2,
                  '0, 1'b0, 0, 0);
         check($sformatf("sat%0d_total", v), int'(total_votes), exp_total);
         check($sformatf("sat%0d_overflow", v), int'(overflow), int'(exp_ovf));
      end
      sel = 3'd3;
      @(negedge clock);
      check("sat_tally3", int'(tally_out), exp_tally[3]);
      repeat (3) @(negedge clock);
      check("sat_overflow_sticky", int'(overflow), 1);

      @(negedge clock);
      check("event_queue_drained", evq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
